// File: rtl/core_result_collector.sv
// core_result_collector: gathers one (SAD, position) pair per core, then scans
// the captured slots one per cycle to find the global minimum SAD and presents
// it under a done/ack handshake.
// Optional build macro COLLECTOR_TIMEOUT_EN: forces a scan of the slots that are
// valid when the TIMEOUT counter expires while waiting for the remaining cores.
module core_result_collector #(
    parameter  int N_CORES = 4,
    parameter  int TIMEOUT = 1024,
    localparam int CW      = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [32*N_CORES-1:0] buf_val_1,
    input  logic [32*N_CORES-1:0] buf_val_2,
    input  logic [N_CORES-1:0]    buf_flag,
    input  logic                  result_ack,
    output logic                  done,
    output logic [31:0]           best_sad,
    output logic [31:0]           best_pos,
    output logic [CW-1:0]         best_core,
    output logic                  overrun,
    output logic                  timed_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t               state;
    logic [31:0]          val1 [N_CORES];
    logic [31:0]          val2 [N_CORES];
    logic [N_CORES-1:0]   valid;
    logic [N_CORES-1:0]   flag_q;
    logic [N_CORES-1:0]   rise;
    logic [CW-1:0]        idx;
    logic                 found;
    logic                 clear;

    assign rise  = buf_flag & ~flag_q;
    assign clear = (state == S_DONE) && result_ack;

    // Slot capture on flag rising edges; a capture in the clear cycle survives the clear
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            flag_q  <= '0;
            valid   <= '0;
            overrun <= 1'b0;
            for (int unsigned k = 0; k < N_CORES; k++) begin
                val1[k] <= '0;
                val2[k] <= '0;
            end
        end else begin
            flag_q <= buf_flag;
            for (int unsigned k = 0; k < N_CORES; k++) begin
                if (rise[k] && !valid[k]) begin
                    val1[k]  <= buf_val_1[32*k +: 32];
                    val2[k]  <= buf_val_2[32*k +: 32];
                    valid[k] <= 1'b1;
                end else if (clear) begin
                    valid[k] <= 1'b0;
                end
                if (rise[k] && valid[k]) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

`ifdef COLLECTOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    logic             tmo;

    assign timed_out = tmo;
`else
    // TIMEOUT only matters when timeout support is built in
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign timed_out      = 1'b0;
`endif

    // Control FSM: wait for reports, sequential min-scan, hold result until ack
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            found     <= 1'b0;
            done      <= 1'b0;
            best_sad  <= '0;
            best_pos  <= '0;
            best_core <= '0;
`ifdef COLLECTOR_TIMEOUT_EN
            cnt       <= '0;
            tmo       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (&valid) begin
                        state <= S_SCAN;
                        idx   <= '0;
                        found <= 1'b0;
`ifdef COLLECTOR_TIMEOUT_EN
                        cnt   <= '0;
                    end else if (|valid) begin
                        if (cnt == CNT_W'(TIMEOUT)) begin
                            state <= S_SCAN;
                            idx   <= '0;
                            found <= 1'b0;
                            cnt   <= '0;
                            tmo   <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                end
                S_SCAN: begin
                    if (valid[idx] && (!found || (val1[idx] < best_sad))) begin
                        best_sad  <= val1[idx];
                        best_pos  <= val2[idx];
                        best_core <= idx;
                        found     <= 1'b1;
                    end
                    if (idx == CW'(N_CORES - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ack) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
`ifdef COLLECTOR_TIMEOUT_EN
                        tmo   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_result_collector.sv
// Directed bench for core_result_collector (N_CORES=4, TIMEOUT=16).
module tb_core_result_collector;

    logic         Clk;
    logic         rst_n;
    logic [127:0] buf_val_1;
    logic [127:0] buf_val_2;
    logic [3:0]   buf_flag;
    logic         result_ack;
    logic         done;
    logic [31:0]  best_sad;
    logic [31:0]  best_pos;
    logic [1:0]   best_core;
    logic         overrun;
    logic         timed_out;

    int n_cmp = 0;
    int n_err = 0;

    core_result_collector #(
        .N_CORES(4),
        .TIMEOUT(16)
    ) dut (
        .Clk        (Clk),
        .Reset      (rst_n),
        .buf_val_1  (buf_val_1),
        .buf_val_2  (buf_val_2),
        .buf_flag   (buf_flag),
        .result_ack (result_ack),
        .done       (done),
        .best_sad   (best_sad),
        .best_pos   (best_pos),
        .best_core  (best_core),
        .overrun    (overrun),
        .timed_out  (timed_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Packed arrays list core 3 first, core 0 last
    typedef struct packed {
        logic [3:0][31:0] sad;
        logic [3:0][31:0] pos;
        logic [31:0]      e_sad;
        logic [31:0]      e_pos;
        logic [1:0]       e_core;
    } vec_t;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("done_drop_after_ack", 32'(done), 32'd0);
    endtask

    vec_t vecs [6];
    int   lat;

    initial begin
        vecs[0] = '{sad: {32'd25, 32'd30, 32'd12, 32'd40},
                    pos: {32'h43, 32'h32, 32'h21, 32'h10},
                    e_sad: 32'd12, e_pos: 32'h21, e_core: 2'd1};
        vecs[1] = '{sad: {32'd7, 32'd7, 32'd9, 32'd7},
                    pos: {32'hA3, 32'hA2, 32'hA1, 32'hA0},
                    e_sad: 32'd7, e_pos: 32'hA0, e_core: 2'd0};
        vecs[2] = '{sad: {32'd5, 32'd300, 32'd200, 32'd100},
                    pos: {32'h3, 32'h2, 32'h1, 32'h0},
                    e_sad: 32'd5, e_pos: 32'h3, e_core: 2'd3};
        vecs[3] = '{sad: {32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF},
                    pos: {32'hD3, 32'hD2, 32'hD1, 32'hD0},
                    e_sad: 32'h7FFF_FFFF, e_pos: 32'hD2, e_core: 2'd2};
        vecs[4] = '{sad: {32'd0, 32'd0, 32'd0, 32'd0},
                    pos: {32'h44, 32'h33, 32'h22, 32'h11},
                    e_sad: 32'd0, e_pos: 32'h11, e_core: 2'd0};
        vecs[5] = '{sad: {32'hFFFF_FFFF, 32'd1, 32'd1, 32'd9},
                    pos: {32'h5D, 32'h5C, 32'h5B, 32'h5A},
                    e_sad: 32'd1, e_pos: 32'h5B, e_core: 2'd1};

        rst_n      = 1'b0;
        buf_val_1  = '0;
        buf_val_2  = '0;
        buf_flag   = '0;
        result_ack = 1'b0;
        tick();
        tick();
        check("rst_done", 32'(done), 32'd0);
        check("rst_best_sad", best_sad, 32'd0);
        check("rst_best_pos", best_pos, 32'd0);
        check("rst_best_core", 32'(best_core), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_timed_out", 32'(timed_out), 32'd0);
        rst_n = 1'b1;
        tick();

        // Table: all flags rise together
        for (int i = 0; i < 6; i++) begin
            buf_val_1 = vecs[i].sad;
            buf_val_2 = vecs[i].pos;
            buf_flag  = 4'hF;
            tick();
            wait_done(lat);
            check("vec_latency", 32'(lat), 32'd5);
            check("vec_best_sad", best_sad, vecs[i].e_sad);
            check("vec_best_pos", best_pos, vecs[i].e_pos);
            check("vec_best_core", 32'(best_core), 32'(vecs[i].e_core));
            check("vec_timed_out", 32'(timed_out), 32'd0);
            buf_flag = 4'h0;
            do_ack();
        end

        // Staggered flags: cores report at cycles 0, 3, 9, 20
        buf_val_1 = {32'd70, 32'd45, 32'd45, 32'd60};
        buf_val_2 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        for (int c = 0; c <= 20; c++) begin
            buf_flag[0] = (c >= 0);
            buf_flag[1] = (c >= 3);
            buf_flag[2] = (c >= 9);
            buf_flag[3] = (c >= 20);
            tick();
            if (done) check("stagger_early_done", 32'(done), 32'd0);
        end
        wait_done(lat);
        check("stagger_latency", 32'(lat), 32'd5);
        check("stagger_best_sad", best_sad, 32'd45);
        check("stagger_best_pos", best_pos, 32'hB1);
        check("stagger_best_core", 32'(best_core), 32'd1);
        do_ack();
        // Flags stay high with no new edge: cleared slots must not rescan
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) check("stagger_slots_cleared", 32'(done), 32'd0);
        end
        buf_flag = 4'h0;
        tick();

        // Overrun: core 2 toggles, first captured values must be kept
        check("overrun_clear_before", 32'(overrun), 32'd0);
        buf_val_1 = {32'd40, 32'd10, 32'd30, 32'd20};
        buf_val_2 = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        buf_flag  = 4'b0100;
        tick();
        buf_val_1 = {32'd40, 32'd1, 32'd30, 32'd20};
        buf_val_2 = {32'hC3, 32'hEE, 32'hC1, 32'hC0};
        buf_flag  = 4'b0000;
        tick();
        buf_flag = 4'b0100;
        tick();
        check("overrun_set", 32'(overrun), 32'd1);
        buf_flag = 4'b1111;
        tick();
        wait_done(lat);
        check("overrun_latency", 32'(lat), 32'd5);
        check("overrun_best_sad", best_sad, 32'd10);
        check("overrun_best_pos", best_pos, 32'hC2);
        check("overrun_best_core", 32'(best_core), 32'd2);
        buf_flag = 4'h0;
        do_ack();
        check("overrun_sticky", 32'(overrun), 32'd1);
        tick();

        // Reset in the middle of a scan
        buf_val_1 = {32'd90, 32'd80, 32'd70, 32'd50};
        buf_val_2 = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        buf_flag  = 4'hF;
        tick();
        tick();
        tick();
        check("midscan_partial_sad", best_sad, 32'd50);
        #2;
        rst_n = 1'b0;
        #1;
        check("midscan_rst_done", 32'(done), 32'd0);
        check("midscan_rst_sad", best_sad, 32'd0);
        check("midscan_rst_pos", best_pos, 32'd0);
        check("midscan_rst_core", 32'(best_core), 32'd0);
        check("midscan_rst_overrun", 32'(overrun), 32'd0);
        buf_flag = 4'h0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done) check("midscan_no_stale_done", 32'(done), 32'd0);
        end
        buf_val_1 = {32'd6, 32'd4, 32'd8, 32'd5};
        buf_val_2 = {32'h73, 32'h72, 32'h71, 32'h70};
        buf_flag  = 4'hF;
        tick();
        wait_done(lat);
        check("post_rst_latency", 32'(lat), 32'd5);
        check("post_rst_best_sad", best_sad, 32'd4);
        check("post_rst_best_pos", best_pos, 32'h72);
        check("post_rst_best_core", 32'(best_core), 32'd2);
        buf_flag = 4'h0;
        do_ack();
        tick();

`ifdef COLLECTOR_TIMEOUT_EN
        // Only cores 0 and 3 report; scan is forced by the timeout
        buf_val_1 = {32'd8, 32'd0, 32'd0, 32'd50};
        buf_val_2 = {32'h93, 32'h0, 32'h0, 32'h90};
        buf_flag  = 4'b1001;
        tick();
        wait_done(lat);
        check("tmo_done_seen", 32'(done), 32'd1);
        check("tmo_not_early", 32'(lat >= 20), 32'd1);
        check("tmo_not_late", 32'(lat <= 22), 32'd1);
        check("tmo_best_sad", best_sad, 32'd8);
        check("tmo_best_pos", best_pos, 32'h93);
        check("tmo_best_core", 32'(best_core), 32'd3);
        check("tmo_flag", 32'(timed_out), 32'd1);
        buf_flag = 4'h0;
        do_ack();
        check("tmo_flag_cleared", 32'(timed_out), 32'd0);
`else
        check("tmo_tied_low", 32'(timed_out), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
